// File: rtl/arith_pkg.sv
// arith_pkg: operation and FSM state encodings shared by the sequential
// arithmetic unit and its testbench-facing top level.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core: iteration down-counter plus one shared 2*WIDTH shift
// register used for both shift-add multiply (LSB first) and restoring divide
// (MSB first). The divide step is only built when ARITH_DIV_EN is defined.
// The *_next outputs present the value after the current step so the top can
// capture the final answer on the edge that ends the last CALC cycle.
module seq_muldiv_core #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
`ifdef ARITH_DIV_EN
  input  logic               is_div,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
`ifdef ARITH_DIV_EN
  output logic [WIDTH-1:0]   quo_next,
  output logic [WIDTH-1:0]   rem_next,
`endif
  output logic [2*WIDTH-1:0] prod_next
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  // {high half, low half}: mul -> {partial product, multiplier},
  // div -> {partial remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_next;

  assign last      = (cnt == CW'(1));
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign prod_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef ARITH_DIV_EN
  logic           is_div_q;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           q_bit;

  // Borrow out of the trial subtraction means the divisor did not fit.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign q_bit     = ~div_diff[WIDTH];
  assign rem_next  = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {acc[WIDTH-2:0], q_bit};
  assign step_next = is_div_q ? {rem_next, quo_next} : prod_next;
`else
  assign step_next = prod_next;
`endif

  // Load operands on accept, then advance one bit per CALC cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      acc  <= '0;
      opnd <= '0;
`ifdef ARITH_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else if (load) begin
      cnt <= CW'(WIDTH);
`ifdef ARITH_DIV_EN
      is_div_q <= is_div;
      acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      opnd     <= is_div ? b : a;
`else
      acc  <= {{WIDTH{1'b0}}, b};
      opnd <= a;
`endif
    end else if (step) begin
      cnt <= cnt - CW'(1);
      acc <= step_next;
    end
  end

endmodule

// File: rtl/seq_arithmetic_unit.sv
// seq_arithmetic_unit: multi-cycle add/sub/mul/div with start/done handshake.
// Add/sub finish in one cycle; mul/div iterate WIDTH cycles in seq_muldiv_core.
// Optional macro ARITH_DIV_EN builds the divider; without it op=11 completes
// immediately with overflow=1 to flag the op as unsupported.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last results
// CALC  | mul/div iterating, one bit per cycle
// DONE  | done pulse cycle, back to IDLE next
module seq_arithmetic_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               carry,
  output logic               overflow,
  output logic               div_by_zero
);

  state_e             state;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic               core_load;
  logic               core_step;
  logic               core_last;
  logic [2*WIDTH-1:0] prod_next;
`ifdef ARITH_DIV_EN
  op_e                op_q;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_next;
`endif

  // Top bit of sub_diff is the borrow, i.e. a < b.
  assign add_sum   = {1'b0, a} + {1'b0, b};
  assign sub_diff  = {1'b0, a} - {1'b0, b};
  assign core_load = (state == IDLE) && start;
  assign core_step = (state == CALC);

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (core_load),
    .step      (core_step),
`ifdef ARITH_DIV_EN
    .is_div    (op == OP_DIV),
    .quo_next  (quo_next),
    .rem_next  (rem_next),
`endif
    .a         (a),
    .b         (b),
    .last      (core_last),
    .prod_next (prod_next)
  );

  // Handshake FSM with registered results and status.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef ARITH_DIV_EN
      op_q        <= OP_ADD;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            result      <= '0;
            remainder   <= '0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef ARITH_DIV_EN
            op_q        <= op_e'(op);
`endif
            case (op_e'(op))
              OP_ADD: begin
                result <= {{(WIDTH-1){1'b0}}, add_sum};
                carry  <= add_sum[WIDTH];
                state  <= DONE;
                done   <= 1'b1;
              end
              OP_SUB: begin
                result <= {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                carry  <= sub_diff[WIDTH];
                state  <= DONE;
                done   <= 1'b1;
              end
              OP_MUL: state <= CALC;
              OP_DIV: begin
`ifdef ARITH_DIV_EN
                if (b == '0) begin
                  result      <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                  remainder   <= a;
                  div_by_zero <= 1'b1;
                  state       <= DONE;
                  done        <= 1'b1;
                end else begin
                  state <= CALC;
                end
`else
                overflow <= 1'b1;
                state    <= DONE;
                done     <= 1'b1;
`endif
              end
              default: state <= IDLE;
            endcase
          end
        end
        CALC: begin
          if (core_last) begin
            state <= DONE;
            done  <= 1'b1;
`ifdef ARITH_DIV_EN
            if (op_q == OP_DIV) begin
              result    <= {{WIDTH{1'b0}}, quo_next};
              remainder <= rem_next;
            end else begin
              result   <= prod_next;
              overflow <= |prod_next[2*WIDTH-1:WIDTH];
            end
`else
            result   <= prod_next;
            overflow <= |prod_next[2*WIDTH-1:WIDTH];
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arithmetic_unit.sv
// Bench for seq_arithmetic_unit at WIDTH=4: directed plan vectors, randomized
// ops against an arithmetic reference model, handshake and reset scenarios.
module tb_seq_arithmetic_unit;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           carry;
  logic           overflow;
  logic           div_by_zero;

  int total = 0;
  int bad   = 0;

  // observations from the last exec_op
  int             o_lat;
  logic           o_busy_ok;
  logic [2*W-1:0] o_res;
  logic [2*W-1:0] o_res_hold;
  logic [W-1:0]   o_rem;
  logic           o_c, o_ov, o_dz;
  logic           o_done_after, o_busy_after;
  time            o_t_acc;

  // reference model outputs
  logic [2*W-1:0] e_res;
  logic [W-1:0]   e_rem;
  logic           e_c, e_ov, e_dz;
  int             e_lat;

  always #5 clk = ~clk;

  seq_arithmetic_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .carry       (carry),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // Plain-arithmetic reference of what each op should report.
  task automatic model(input logic [1:0] o, input int x, input int y);
    e_rem = '0; e_c = 1'b0; e_ov = 1'b0; e_dz = 1'b0; e_lat = 1;
    case (o)
      2'd0: begin e_res = (2*W)'(x + y); e_c = (x + y) > MAXV; end
      2'd1: begin e_res = (2*W)'((x - y + MAXV + 1) % (MAXV + 1)); e_c = (x < y); end
      2'd2: begin e_res = (2*W)'(x * y); e_ov = (x * y) > MAXV; e_lat = W + 1; end
      default: begin
`ifdef ARITH_DIV_EN
        if (y == 0) begin
          e_res = (2*W)'(MAXV); e_rem = W'(x); e_dz = 1'b1;
        end else begin
          e_res = (2*W)'(x / y); e_rem = W'(x % y); e_lat = W + 1;
        end
`else
        e_res = '0; e_ov = 1'b1;
`endif
      end
    endcase
  endtask

  // Issue one op in the next cycle and observe it through to the idle cycle.
  task automatic exec_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    o_t_acc = $time;
    #1;
    start = 1'b0;
    op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    o_lat = 1;
    o_busy_ok = 1'b1;
    while (!done && o_lat < 40) begin
      if (busy !== 1'b1) o_busy_ok = 1'b0;
      @(posedge clk); #1;
      o_lat++;
    end
    if (done !== 1'b1) o_lat = -1;
    if (busy !== 1'b1) o_busy_ok = 1'b0;
    o_res = result; o_rem = remainder; o_c = carry; o_ov = overflow; o_dz = div_by_zero;
    @(posedge clk); #1;
    o_done_after = done; o_busy_after = busy; o_res_hold = result;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; op = 2'b10; a = '1; b = '1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=00", result); end
    total++; if ({remainder, carry, overflow, div_by_zero} !== '0) begin
      bad++; $display("FAIL reset_status got=%h/%b%b%b want=0", remainder, carry, overflow, div_by_zero);
    end
    @(negedge clk);
    start = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]   t_op [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [W-1:0] t_a  [8] = '{4'd9, 4'd3, 4'd5, 4'd15, 4'd3, 4'd13, 4'd7, 4'd1};
    logic [W-1:0] t_b  [8] = '{4'd8, 4'd5, 4'd3, 4'd15, 4'd4, 4'd4, 4'd0, 4'd1};
    for (int i = 0; i < 8; i++) begin
      exec_op(t_op[i], t_a[i], t_b[i]);
      model(t_op[i], int'(t_a[i]), int'(t_b[i]));
      total++; if (o_lat != e_lat) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, o_lat, e_lat); end
      total++; if (o_busy_ok !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=dropped want=held", i); end
      total++; if (o_res !== e_res) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, o_res, e_res); end
      total++; if (o_rem !== e_rem) begin bad++; $display("FAIL dir%0d_remainder got=%h want=%h", i, o_rem, e_rem); end
      total++; if ({o_c, o_ov, o_dz} !== {e_c, e_ov, e_dz}) begin
        bad++; $display("FAIL dir%0d_flags c/ov/dz got=%b%b%b want=%b%b%b", i, o_c, o_ov, o_dz, e_c, e_ov, e_dz);
      end
      total++; if ({o_done_after, o_busy_after} !== 2'b00) begin
        bad++; $display("FAIL dir%0d_after_done done/busy got=%b%b want=00", i, o_done_after, o_busy_after);
      end
      total++; if (o_res_hold !== o_res) begin bad++; $display("FAIL dir%0d_hold got=%h want=%h", i, o_res_hold, o_res); end
    end
  endtask

  task automatic test_random();
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    for (int i = 0; i < 60; i++) begin
      r_op = 2'($urandom);
      r_a  = W'($urandom);
      r_b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      exec_op(r_op, r_a, r_b);
      model(r_op, int'(r_a), int'(r_b));
      total++; if (o_lat != e_lat) begin bad++; $display("FAIL rnd%0d_latency op=%0d got=%0d want=%0d", i, r_op, o_lat, e_lat); end
      total++; if (o_res !== e_res || o_rem !== e_rem) begin
        bad++; $display("FAIL rnd%0d_value op=%0d a=%0d b=%0d got=%h/%h want=%h/%h", i, r_op, r_a, r_b, o_res, o_rem, e_res, e_rem);
      end
      total++; if ({o_c, o_ov, o_dz} !== {e_c, e_ov, e_dz}) begin
        bad++; $display("FAIL rnd%0d_flags op=%0d a=%0d b=%0d got=%b%b%b want=%b%b%b", i, r_op, r_a, r_b, o_c, o_ov, o_dz, e_c, e_ov, e_dz);
      end
      total++; if (o_done_after !== 1'b0 || o_busy_after !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_pulse done/busy got=%b%b want=00", i, o_done_after, o_busy_after);
      end
    end
  endtask

  task automatic test_back_to_back();
    time t_first;
    exec_op(2'd0, 4'd2, 4'd3);
    t_first = o_t_acc;
    exec_op(2'd0, 4'd4, 4'd5);
    total++; if (o_t_acc - t_first != 20) begin
      bad++; $display("FAIL b2b_add_spacing got=%0t want=20", o_t_acc - t_first);
    end
    total++; if (o_res !== 8'h09) begin bad++; $display("FAIL b2b_add_result got=%h want=09", o_res); end
    exec_op(2'd2, 4'd5, 4'd5);
    t_first = o_t_acc;
    exec_op(2'd2, 4'd2, 4'd7);
    total++; if (o_t_acc - t_first != 10 * (W + 2)) begin
      bad++; $display("FAIL b2b_mul_spacing got=%0t want=%0d", o_t_acc - t_first, 10 * (W + 2));
    end
    total++; if (o_res !== 8'h0E) begin bad++; $display("FAIL b2b_mul_result got=%h want=0e", o_res); end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int lat_seen = -1;
    logic [2*W-1:0] res_seen = '0;
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 4'd6; b = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      // cycle T0+c sampled here
      if (c == 2) begin start = 1'b1; op = 2'd0; a = 4'd1; b = 4'd1; end
      if (c == 3) start = 1'b0;
      if (done === 1'b1) begin pulses++; lat_seen = c; res_seen = result; end
      @(posedge clk); #1;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ignore_pulses got=%0d want=1", pulses); end
    total++; if (lat_seen != W + 1) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat_seen, W + 1); end
    total++; if (res_seen !== 8'h2A) begin bad++; $display("FAIL ignore_result got=%h want=2a", res_seen); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 4'd15; b = 4'd15;
    @(posedge clk); #1;           // cycle T0+1
    start = 1'b0;
    @(posedge clk); #1;           // cycle T0+2
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrst_busy_done got=%b%b want=00", busy, done); end
    total++; if ({result, remainder, carry, overflow, div_by_zero} !== '0) begin
      bad++; $display("FAIL midrst_outputs got=%h/%h/%b%b%b want=0", result, remainder, carry, overflow, div_by_zero);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_ghost_done got=%0d want=0", pulses); end
    exec_op(2'd0, 4'd1, 4'd1);
    total++; if (o_res !== 8'h02 || o_lat != 1) begin
      bad++; $display("FAIL midrst_fresh_add got=%h lat=%0d want=02 lat=1", o_res, o_lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_arithmetic_unit.md
# seq_arithmetic_unit

Parametrised, multi-cycle arithmetic unit for the calculator datapath. It performs add, subtract, multiply and divide on WIDTH-bit unsigned operands. Operations are started by a start/done handshake, and multiply and divide run as iterative shift-add and restoring-divide loops. It replaces the combinational four-operation path in front of the 7-segment display logic. It also exports carry/borrow, overflow, remainder and divide-by-zero status for the decimal-point indicators.

## Interface
- WIDTH, 4, operand width in bits; must be 2 or greater.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
- a  in  WIDTH  first operand / dividend.
- b  in  WIDTH  second operand / divisor.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- result  out  2*WIDTH  sum, difference, product or quotient, zero-extended.
- remainder  out  WIDTH  divide remainder; 0 for all other ops.
- carry  out  1  add carry-out, or sub borrow (a<b); 0 for mul/div.
- overflow  out  1  mul: product[2*WIDTH-1:WIDTH] is nonzero; 0 otherwise (see Configuration).
- div_by_zero  out  1  div with b==0.

## Operation
- States: IDLE, CALC, DONE.
- Accept: on a clock edge with start=1 and state IDLE, the block latches a, b and op.
- add/sub go IDLE→DONE. Result is computed at the accept edge.
- mul/div go IDLE→CALC. CALC lasts exactly WIDTH cycles, then DONE. Divide by zero goes IDLE→DONE.
- DONE lasts one cycle, drives done=1, then returns to IDLE.
- start in CALC or DONE is ignored, and operand/op changes in those states have no effect.
- add: result = a+b, with carry = bit WIDTH of the sum.
- sub: result = {WIDTH'b0, (a-b) mod 2^WIDTH}, with carry = (a<b).
- mul: unsigned shift-add, one multiplier bit per CALC cycle, LSB first.
- div: restoring division, one quotient bit per CALC cycle, MSB first. result = quotient, remainder = a mod b.
- Divide by zero: result = all ones in the low WIDTH bits and zeros above; remainder = a; div_by_zero = 1.
- result and all status outputs hold their values from done until the next accepted start. Status outputs not relevant to the accepted op clear to 0 at the accept edge.
- Reset (any state, including mid-CALC): state IDLE. busy, done, result, remainder, carry, overflow and div_by_zero all go to 0. An aborted operation never produces done.

## Timing
- Accept edge is T0.
- add/sub and divide by zero: busy=1 and done=1 in cycle T0+1; IDLE again at T0+2.
- mul/div: busy=1 for cycles T0+1..T0+WIDTH+1; done=1 in cycle T0+WIDTH+1.
- Earliest next accept is the edge ending the first IDLE cycle after done. Peak throughput is one add every 2 cycles and one mul/div every WIDTH+2 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- ARITH_DIV_EN defined: divider datapath is compiled in and behaves as described above.
- ARITH_DIV_EN undefined: divider datapath is removed. op=11 takes the add/sub path (done at T0+1) with result=0, remainder=0, div_by_zero=0 and overflow=1, which marks the op as unsupported.

## Structure
- Shared package arith_pkg holds:
  - the op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the state encoding IDLE/CALC/DONE.
- One sub-module, seq_muldiv_core, holds the iteration counter, shift registers and the mul/div step logic. Under ARITH_DIV_EN only, it contains the restoring-divide step.
- The top level holds the FSM, add/sub logic, handshake and output registers.

## Test plan
All scenarios run with WIDTH=4.
- add a=9, b=8 → done at T0+1, result=8'h11, carry=1, overflow=0.
- sub a=3, b=5 → result=8'h0E, carry=1. Then sub a=5, b=3 → result=8'h02, carry=0.
- mul a=15, b=15 → busy for 5 cycles, done at T0+5, result=8'hE1, overflow=1. mul a=3, b=4 → result=8'h0C, overflow=0.
- div a=13, b=4 → done at T0+5, result=8'h03, remainder=1. div a=7, b=0 → done at T0+1, result=8'h0F, remainder=7, div_by_zero=1.
- start pulsed with new operands during CALC of mul 6×7 → ignored. Result=8'h2A, and exactly one done pulse.
- reset_n=0 at T0+2 of a mul → next cycle all outputs are 0 and state is IDLE, with no done pulse. A fresh add a=1, b=1 then returns result=8'h02.
